// File: rtl/serial_comparator_ctrl_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM states,
// result codes and the index-width helper.
package serial_comparator_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result codes are ordered {o1, o2, o3} = {A>B, A==B, A<B}.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // The index register needs at least one bit, even for WIDTH=1.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_comparator_ctrl_if.sv
// Request/response bundle of the serial comparator: start plus operands in,
// busy/done handshake and one-hot result out.
interface serial_comparator_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             o1;
  logic             o2;
  logic             o3;

  modport master (
    output start, A, B,
    input  busy, done, o1, o2, o3
  );

  modport slave (
    input  start, A, B,
    output busy, done, o1, o2, o3
  );

endinterface

// File: rtl/serial_comparator_ctrl_cmp.sv
// Single-bit magnitude comparator cell; purely combinational.
// o1 = a>b, o2 = a==b, o3 = a<b.
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic o1,
  output logic o2,
  output logic o3
);

  assign o1 = a & ~b;
  assign o2 = ~(a ^ b);
  assign o3 = ~a & b;

endmodule

// File: rtl/serial_comparator_ctrl.sv
// MSB-first bit-serial comparator of two WIDTH-bit unsigned operands, stopping
// at the first differing bit and reporting through a start/busy/done handshake.
module serial_comparator_ctrl
  import serial_comparator_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_comparator_ctrl_if.slave  bus
);

  localparam int                IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [2:0]         res_reg;

  logic               bit_a;
  logic               bit_b;
  logic               cell_gt;
  logic               cell_eq;
  logic               cell_lt;

  // Only the latched operands feed the cell, so bus activity mid-scan is inert.
  assign bit_a = a_reg[idx_reg];
  assign bit_b = b_reg[idx_reg];

  comparator_1bit u_cmp (
    .a  (bit_a),
    .b  (bit_b),
    .o1 (cell_gt),
    .o2 (cell_eq),
    .o3 (cell_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      res_reg   <= RES_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B;
            idx_reg   <= IDX_LAST;
            busy_reg  <= 1'b1;
            state_reg <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!cell_eq) begin
            res_reg   <= {cell_gt, 1'b0, cell_lt};
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (idx_reg == '0) begin
            res_reg   <= RES_EQ;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg - 1'b1;
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here; the next accept is in IDLE.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.o1   = res_reg[2];
  assign bus.o2   = res_reg[1];
  assign bus.o3   = res_reg[0];

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Self-checking bench for serial_comparator_ctrl (WIDTH=8): vector table,
// hand-written corner sequences and randomized compares against a simple model.
module tb_serial_comparator_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_comparator_ctrl_if #(.WIDTH(W)) bus ();

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [2:0] last_res;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   res;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] outs();
    return {bus.o1, bus.o2, bus.o3};
  endfunction

  // Reference: ordering from integer compare; latency from the highest differing bit.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2:0] res, output int lat);
    logic [W-1:0] x;
    x = a ^ b;
    if (a > b)       res = 3'b100;
    else if (a == b) res = 3'b010;
    else             res = 3'b001;
    lat = W;
    for (int i = 0; i < W; i++)
      if (x[i]) lat = W - i;
  endfunction

  // Issue one compare from an IDLE cycle and follow it through DONE back to IDLE.
  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] exp_res, input int exp_lat,
                             input bit noisy, input string name);
    int lat;
    lat = -1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    check({name, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    check({name, "_hold_after_accept"}, 32'(outs()), 32'(last_res));
    for (int k = 1; k <= W + 4; k++) begin
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
      end
      tick();
      if (bus.done) begin
        lat = k;
        break;
      end
      check({name, "_busy_scan"}, 32'(bus.busy), 32'd1);
      check({name, "_hold_scan"}, 32'(outs()), 32'(last_res));
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, 32'(outs()), 32'(exp_res));
    check({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    last_res = exp_res;
    tick();
    check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({name, "_result_hold"}, 32'(outs()), 32'(exp_res));
    bus.start = 1'b0;
    $display("txn %s A=%h B=%h result=%b latency=%0d", name, a, b, outs(), lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] m_res;
    int         m_lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_checks = 0;
    n_fail   = 0;
    last_res = 3'b000;

    vecs[0] = '{8'hA5, 8'h25, 3'b100, 1};
    vecs[1] = '{8'h3C, 8'h3C, 3'b010, 8};
    vecs[2] = '{8'h10, 8'h11, 3'b001, 8};
    vecs[3] = '{8'h0F, 8'hF0, 3'b001, 1};
    vecs[4] = '{8'h02, 8'h04, 3'b001, 6};
    vecs[5] = '{8'hFF, 8'hFE, 3'b100, 8};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(outs()), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'({bus.busy, bus.done, outs()}), 32'd0);

    for (int i = 0; i < 6; i++)
      run_compare(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));

    // Isolation: a second request during SCAN/DONE must not be taken.
    bus.start = 1'b1;
    bus.A     = 8'h80;
    bus.B     = 8'h7F;
    tick();
    bus.A = 8'h00;
    bus.B = 8'hFF;
    check("iso_busy", 32'(bus.busy), 32'd1);
    tick();
    check("iso_done", 32'(bus.done), 32'd1);
    check("iso_result", 32'(outs()), 32'(3'b100));
    tick();
    bus.start = 1'b0;
    check("iso_no_rescan", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("iso_no_second_done", 32'({bus.busy, bus.done}), 32'd0);
    end
    check("iso_result_hold", 32'(outs()), 32'(3'b100));
    $display("txn isolation A=80 B=7F result=%b", outs());
    last_res = 3'b100;

    // Asynchronous reset during the 4th SCAN cycle of an equal-operand compare.
    bus.start = 1'b1;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_result", 32'(outs()), 32'd0);
    #1 rst = 1'b0;
    last_res = 3'b000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rst_mid_no_done", 32'({bus.busy, bus.done}), 32'd0);
    end
    $display("txn reset_abort A=01 B=01 result=%b", outs());
    run_compare(8'h02, 8'h04, 3'b001, 6, 1'b0, "after_reset");

    // Back-to-back: second start in the IDLE cycle right after DONE.
    run_compare(8'hF0, 8'h0F, 3'b100, 1, 1'b0, "b2b_first");
    run_compare(8'h0F, 8'hF0, 3'b001, 1, 1'b0, "b2b_second");

    // Randomized compares with bus noise while the scan is in flight.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      model(ra, rb, m_res, m_lat);
      run_compare(ra, rb, m_res, m_lat, 1'b1, $sformatf("rand%0d", i));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        check("rand_gap_idle", 32'({bus.busy, bus.done}), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
